psram_resp: RTL and testbench
=============================

// Module: psram_resp
// PURPOSE
//  Synthesizable PSRAM device-side responder: the far end of the psram controller's SPI/QSPI/QPI/OPI link.
//  Oversamples controller SCK/CE/IO on the system clock, decodes inst/addr/latency/data phases, serves a byte array.
//  Used as FPGA/sim stand-in for a PSRAM die and as loop-back target for controller verification.
// PARAMETERS
//  DEPTH      1024  bytes of backing store; power of two; address uses low $clog2(DEPTH) bits, wraps
//  SYNC_STAGE 2     input synchronizer depth on SCK/CE/IO
// PORTS
//  clk_i           in   1  system clock; must be >= 8x SCK (controller PSCR DIV8 or slower)
//  rst_n_i         in   1  async active-low reset
//  mode_i          in   2  PSRAM_MODE_SPI/QSPI/QPI/OPI, static while CE high-to-low
//  wcmd_i/rcmd_i   in   8  write / read instruction codes
//  ccmd_i          in   8  config-write instruction code (writes cfg_o)
//  wlc_i/rlc_i     in   8  write / read latency in SCK rising edges
//  psram_sck_i     in   1  controller SCK
//  psram_ce_i      in   1  controller CE, active-low
//  psram_io_in_i   in   8  controller IO out
//  psram_io_out_o  out  8  read data to controller
//  psram_io_en_o   out  8  per-lane output enable
//  psram_dqs_out_o out  1  read strobe (PSRAM_RESP_DQS_EN only, else 0)
//  psram_dqs_en_o  out  1  strobe enable (PSRAM_RESP_DQS_EN only, else 0)
//  cfg_o           out  8  config register
//  busy_o          out  1  CE-low transaction in progress
//  err_o           out  1  1-cycle pulse on unknown instruction
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, cfg_o 0; memory array not reset.
//  Inputs pass SYNC_STAGE flops; rise/fall of synced SCK detected next cycle; IO sampled from same-aligned stage.
//  Lanes: SPI inst/addr/data 1 (in io[0], out io[1]); QSPI inst 1, addr/data 4; QPI all 4; OPI all 8 (SDR).
//  Inst = 8 bits, addr = 32 bits, MSB first; bits sampled on SCK rising edge.
//  FSM: IDLE -CE fall-> INST -8/lanes edges-> decode: wcmd/rcmd/ccmd->ADDR, else IGNR + err_o.
//   ADDR -32/lanes edges-> LATN (rlc/wlc; count 0 skips to data) -> WDATA or RDATA; ccmd goes ADDR->WDATA, no latency.
//   WDATA: each 8/lanes edges assemble byte, write mem[addr], addr+1 wraps mod DEPTH; ccmd writes cfg_o instead.
//   RDATA: drive bits on SCK falling edge; first byte present on falling edge ending LATN; addr+1 per byte, wraps.
//   IGNR: hold until CE rise. Any state: synced CE rise -> IDLE same cycle, io_en 0, partial byte discarded.
//  psram_io_en_o set only in RDATA on used lanes; cleared on CE rise.
//  Rising edge and CE rise in same cycle: CE rise wins, edge ignored.
//  Rule: 3-cycle sync+detect latency + 1 output flop must fit in SCK low half; DIV4 unsupported.
//  busy_o = FSM != IDLE. Mode change mid-transaction ignored (latched at CE fall).
// CONFIGURATION
//  PSRAM_RESP_DQS_EN defined: in OPI RDATA, dqs_en_o=1 and dqs_out_o toggles with each read byte update,
//   low on entry; also drives 0 and en=1 for final LATN half-cycle. Undefined: both tied 0.
// STRUCTURE
//  psram_define.sv: add `PSRAM_RESP_FSM_{IDLE,INST,ADDR,LATN,WDATA,RDATA,IGNR}; reuse `PSRAM_MODE_*.
//  Sub-module psram_resp_sync: SYNC_STAGE flop chain + SCK rise/fall + CE rise/fall pulse generation.
//  Top: FSM, bit/edge counter, shift register, address counter, memory array, output drivers.
// TESTING
//  SPI write wcmd=0x38 addr 0x10 data A5,5A, then read rcmd=0xEB rlc=6 -> io[1] returns A5,5A.
//  OPI write 4 bytes at addr DEPTH-2 -> bytes land at DEPTH-2, DEPTH-1, 0, 1 (wrap).
//  Unknown inst 0x77 in QPI -> err_o one pulse, io_en stays 0, IGNR until CE high, busy_o drops.
//  CE raised after 3 of 8 OPI... SPI data bits -> no memory write, FSM IDLE, next transaction normal.
//  ccmd=0xC0 addr 0 data 0x2B -> cfg_o==0x2B; rst_n_i low mid-read -> outputs 0, mem intact on re-read.
//  PSRAM_RESP_DQS_EN: OPI read 4 bytes -> 4 dqs_out_o toggles aligned with byte changes, dqs_en_o low after CE.

Source files
------------

// File: rtl/psram_resp_pkg.sv
// Shared definitions for the PSRAM device-side responder.
// Contents: link mode codes, FSM state encoding, transaction kind, and
// helpers giving lane count and SCK-edge counts per mode and phase.
package psram_resp_pkg;

  localparam logic [1:0] PSRAM_MODE_SPI  = 2'd0;
  localparam logic [1:0] PSRAM_MODE_QSPI = 2'd1;
  localparam logic [1:0] PSRAM_MODE_QPI  = 2'd2;
  localparam logic [1:0] PSRAM_MODE_OPI  = 2'd3;

  typedef enum logic [2:0] {
    PSRAM_RESP_FSM_IDLE,
    PSRAM_RESP_FSM_INST,
    PSRAM_RESP_FSM_ADDR,
    PSRAM_RESP_FSM_LATN,
    PSRAM_RESP_FSM_WDATA,
    PSRAM_RESP_FSM_RDATA,
    PSRAM_RESP_FSM_IGNR
  } psram_resp_fsm_e;

  typedef enum logic [1:0] {
    PSRAM_RESP_OP_WRITE,
    PSRAM_RESP_OP_READ,
    PSRAM_RESP_OP_CFG
  } psram_resp_op_e;

  // Active IO lanes; QSPI sends its instruction on a single lane.
  function automatic logic [7:0] psram_lanes(input logic [1:0] mode, input logic inst_phase);
    case (mode)
      PSRAM_MODE_SPI:  return 8'd1;
      PSRAM_MODE_QSPI: return inst_phase ? 8'd1 : 8'd4;
      PSRAM_MODE_QPI:  return 8'd4;
      default:         return 8'd8;
    endcase
  endfunction

  // SCK rising edges needed to move one byte.
  function automatic logic [7:0] psram_byte_edges(input logic [7:0] lanes);
    case (lanes)
      8'd1:    return 8'd8;
      8'd4:    return 8'd2;
      default: return 8'd1;
    endcase
  endfunction

  // SCK rising edges needed to move the 32-bit address.
  function automatic logic [7:0] psram_addr_edges(input logic [7:0] lanes);
    case (lanes)
      8'd1:    return 8'd32;
      8'd4:    return 8'd8;
      default: return 8'd4;
    endcase
  endfunction

endpackage

// File: rtl/psram_resp_sync.sv
// Input synchronizer and edge detector for the PSRAM link.
// Ports:
//   clk_i, rst_n_i          system clock, async active-low reset
//   sck_i, ce_i, io_i[7:0]  raw controller SCK, CE (active-low), IO
//   sck_rise_o/sck_fall_o   one-cycle pulses on synced SCK edges
//   ce_rise_o/ce_fall_o     one-cycle pulses on synced CE edges
//   io_o[7:0]               IO from the same stage used for edge detection,
//                           so data is aligned with the SCK edge pulses
module psram_resp_sync #(
  parameter int SYNC_STAGE = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       sck_i,
  input  logic       ce_i,
  input  logic [7:0] io_i,
  output logic       sck_rise_o,
  output logic       sck_fall_o,
  output logic       ce_rise_o,
  output logic       ce_fall_o,
  output logic [7:0] io_o
);

  // Stage layout: {sck, ce, io[7:0]}. CE resets high so that leaving reset
  // with CE deasserted never produces a spurious fall.
  localparam logic [9:0] STAGE_RST = 10'b01_0000_0000;

  logic [SYNC_STAGE-1:0][9:0] r_stage;
  logic                       r_sck_prev;
  logic                       r_ce_prev;
  logic [9:0]                 w_last;

  assign w_last = r_stage[SYNC_STAGE-1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stage    <= {SYNC_STAGE{STAGE_RST}};
      r_sck_prev <= 1'b0;
      r_ce_prev  <= 1'b1;
    end else begin
      r_stage[0] <= {sck_i, ce_i, io_i};
      for (int i = 1; i < SYNC_STAGE; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
      r_sck_prev <= w_last[9];
      r_ce_prev  <= w_last[8];
    end
  end

  assign sck_rise_o = w_last[9] & ~r_sck_prev;
  assign sck_fall_o = ~w_last[9] & r_sck_prev;
  assign ce_rise_o  = w_last[8] & ~r_ce_prev;
  assign ce_fall_o  = ~w_last[8] & r_ce_prev;
  assign io_o       = w_last[7:0];

endmodule

// File: rtl/psram_resp.sv
// PSRAM device-side responder: far end of a SPI/QSPI/QPI/OPI PSRAM link.
// Oversamples SCK/CE/IO on clk_i, decodes instruction/address/latency/data
// phases and serves a DEPTH-byte array (address wraps modulo DEPTH).
// Optional feature macro: PSRAM_RESP_DQS_EN (OPI read strobe).
// Ports:
//   clk_i, rst_n_i                  system clock (>= 8x SCK), async active-low reset
//   mode_i                          link mode, latched at CE fall
//   wcmd_i/rcmd_i/ccmd_i            write / read / config-write instruction codes
//   wlc_i/rlc_i                     write / read latency in SCK rising edges
//   psram_sck_i/ce_i/io_in_i        controller SCK, CE (active-low), IO
//   psram_io_out_o/psram_io_en_o    read data and per-lane output enable
//   psram_dqs_out_o/psram_dqs_en_o  read strobe and its enable
//   cfg_o                           config register
//   busy_o                          transaction in progress
//   err_o                           one-cycle pulse on unknown instruction
module psram_resp
  import psram_resp_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int SYNC_STAGE = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] mode_i,
  input  logic [7:0] wcmd_i,
  input  logic [7:0] rcmd_i,
  input  logic [7:0] ccmd_i,
  input  logic [7:0] wlc_i,
  input  logic [7:0] rlc_i,
  input  logic       psram_sck_i,
  input  logic       psram_ce_i,
  input  logic [7:0] psram_io_in_i,
  output logic [7:0] psram_io_out_o,
  output logic [7:0] psram_io_en_o,
  output logic       psram_dqs_out_o,
  output logic       psram_dqs_en_o,
  output logic [7:0] cfg_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam int AW = $clog2(DEPTH);

  logic       w_sck_rise, w_sck_fall, w_ce_rise, w_ce_fall;
  logic [7:0] w_io;

  psram_resp_sync #(.SYNC_STAGE(SYNC_STAGE)) u_sync (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .sck_i      (psram_sck_i),
    .ce_i       (psram_ce_i),
    .io_i       (psram_io_in_i),
    .sck_rise_o (w_sck_rise),
    .sck_fall_o (w_sck_fall),
    .ce_rise_o  (w_ce_rise),
    .ce_fall_o  (w_ce_fall),
    .io_o       (w_io)
  );

  psram_resp_fsm_e r_state, w_state_next;
  psram_resp_op_e  r_op, w_op_next;
  logic [1:0]      r_mode, w_mode_next;
  logic [7:0]      r_cnt, w_cnt_next, w_cnt_inc;
  logic [31:0]     r_shift, w_shift_next, w_shift_in;
  logic [AW-1:0]   r_addr, w_addr_next;
  logic [7:0]      r_cfg, w_cfg_next;
  logic            r_err, w_err_next;
  logic [7:0]      r_io_out, w_io_out_next;
  logic [7:0]      r_io_en, w_io_en_next;
  logic            w_mem_we;
  logic [7:0]      w_lanes, w_byte_edges, w_lat, w_lane_mask, w_chunk;
  logic [7:0]      r_mem [DEPTH];
  logic [7:0]      r_mem_q;
  logic            w_unused;

`ifdef PSRAM_RESP_DQS_EN
  logic r_dqs_out, w_dqs_out_next, r_dqs_en, w_dqs_en_next;
`endif

  assign w_unused     = &{1'b0, w_shift_in[31:AW]};
  assign w_lanes      = psram_lanes(r_mode, r_state == PSRAM_RESP_FSM_INST);
  assign w_byte_edges = psram_byte_edges(w_lanes);
  assign w_lat        = (r_op == PSRAM_RESP_OP_READ) ? rlc_i : wlc_i;
  assign w_cnt_inc    = r_cnt + 8'd1;

  // Incoming bits enter at the LSB end so the completed field is MSB first.
  always_comb begin
    w_shift_in = {r_shift[23:0], w_io};
    case (w_lanes)
      8'd1:    w_shift_in = {r_shift[30:0], w_io[0]};
      8'd4:    w_shift_in = {r_shift[27:0], w_io[3:0]};
      default: w_shift_in = {r_shift[23:0], w_io};
    endcase
  end

  // Read chunk for the current edge count; SPI returns data on io[1].
  always_comb begin
    w_chunk     = r_mem_q;
    w_lane_mask = 8'hFF;
    case (w_lanes)
      8'd1: begin
        w_chunk     = {6'b0, r_mem_q[3'd7 - r_cnt[2:0]], 1'b0};
        w_lane_mask = 8'h02;
      end
      8'd4: begin
        w_chunk     = {4'h0, r_cnt[0] ? r_mem_q[3:0] : r_mem_q[7:4]};
        w_lane_mask = 8'h0F;
      end
      default: begin
        w_chunk     = r_mem_q;
        w_lane_mask = 8'hFF;
      end
    endcase
  end

  always_comb begin
    w_state_next  = r_state;
    w_op_next     = r_op;
    w_mode_next   = r_mode;
    w_cnt_next    = r_cnt;
    w_shift_next  = r_shift;
    w_addr_next   = r_addr;
    w_cfg_next    = r_cfg;
    w_err_next    = 1'b0;
    w_io_out_next = r_io_out;
    w_io_en_next  = r_io_en;
    w_mem_we      = 1'b0;
`ifdef PSRAM_RESP_DQS_EN
    w_dqs_out_next = r_dqs_out;
    w_dqs_en_next  = r_dqs_en;
`endif

    if (w_ce_rise) begin
      // CE rise overrides any same-cycle SCK edge; partial bytes are dropped.
      w_state_next  = PSRAM_RESP_FSM_IDLE;
      w_cnt_next    = 8'd0;
      w_io_out_next = 8'h00;
      w_io_en_next  = 8'h00;
`ifdef PSRAM_RESP_DQS_EN
      w_dqs_out_next = 1'b0;
      w_dqs_en_next  = 1'b0;
`endif
    end else begin
      case (r_state)
        PSRAM_RESP_FSM_IDLE: begin
          if (w_ce_fall) begin
            w_state_next = PSRAM_RESP_FSM_INST;
            w_mode_next  = mode_i;
            w_cnt_next   = 8'd0;
          end
        end

        PSRAM_RESP_FSM_INST: begin
          if (w_sck_rise) begin
            w_shift_next = w_shift_in;
            if (w_cnt_inc == w_byte_edges) begin
              w_cnt_next   = 8'd0;
              w_state_next = PSRAM_RESP_FSM_ADDR;
              if (w_shift_in[7:0] == wcmd_i)      w_op_next = PSRAM_RESP_OP_WRITE;
              else if (w_shift_in[7:0] == rcmd_i) w_op_next = PSRAM_RESP_OP_READ;
              else if (w_shift_in[7:0] == ccmd_i) w_op_next = PSRAM_RESP_OP_CFG;
              else begin
                w_state_next = PSRAM_RESP_FSM_IGNR;
                w_err_next   = 1'b1;
              end
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end
        end

        PSRAM_RESP_FSM_ADDR: begin
          if (w_sck_rise) begin
            w_shift_next = w_shift_in;
            if (w_cnt_inc == psram_addr_edges(w_lanes)) begin
              w_cnt_next  = 8'd0;
              w_addr_next = w_shift_in[AW-1:0];
              if (r_op == PSRAM_RESP_OP_CFG) begin
                w_state_next = PSRAM_RESP_FSM_WDATA;
              end else if (w_lat != 8'd0) begin
                w_state_next = PSRAM_RESP_FSM_LATN;
              end else if (r_op == PSRAM_RESP_OP_READ) begin
                w_state_next = PSRAM_RESP_FSM_RDATA;
`ifdef PSRAM_RESP_DQS_EN
                if (r_mode == PSRAM_MODE_OPI) begin
                  w_dqs_out_next = 1'b0;
                  w_dqs_en_next  = 1'b1;
                end
`endif
              end else begin
                w_state_next = PSRAM_RESP_FSM_WDATA;
              end
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end
        end

        PSRAM_RESP_FSM_LATN: begin
          if (w_sck_rise) begin
            if (w_cnt_inc == w_lat) begin
              w_cnt_next   = 8'd0;
              w_state_next = (r_op == PSRAM_RESP_OP_READ) ? PSRAM_RESP_FSM_RDATA
                                                           : PSRAM_RESP_FSM_WDATA;
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end
`ifdef PSRAM_RESP_DQS_EN
          // Falling edge ahead of the last latency edge opens the strobe low.
          if (w_sck_fall && r_op == PSRAM_RESP_OP_READ && r_mode == PSRAM_MODE_OPI &&
              w_cnt_inc == w_lat) begin
            w_dqs_out_next = 1'b0;
            w_dqs_en_next  = 1'b1;
          end
`endif
        end

        PSRAM_RESP_FSM_WDATA: begin
          if (w_sck_rise) begin
            w_shift_next = w_shift_in;
            if (w_cnt_inc == w_byte_edges) begin
              w_cnt_next = 8'd0;
              if (r_op == PSRAM_RESP_OP_CFG) begin
                w_cfg_next = w_shift_in[7:0];
              end else begin
                w_mem_we    = 1'b1;
                w_addr_next = r_addr + 1'b1;
              end
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end
        end

        PSRAM_RESP_FSM_RDATA: begin
          if (w_sck_fall) begin
            w_io_out_next = w_chunk;
            w_io_en_next  = w_lane_mask;
`ifdef PSRAM_RESP_DQS_EN
            if (r_mode == PSRAM_MODE_OPI) begin
              w_dqs_out_next = ~r_dqs_out;
              w_dqs_en_next  = 1'b1;
            end
`endif
            if (w_cnt_inc == w_byte_edges) begin
              w_cnt_next  = 8'd0;
              w_addr_next = r_addr + 1'b1;
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end
        end

        default: begin
          // IGNR waits for CE rise, handled above.
          w_state_next = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= PSRAM_RESP_FSM_IDLE;
      r_op     <= PSRAM_RESP_OP_WRITE;
      r_mode   <= PSRAM_MODE_SPI;
      r_cnt    <= 8'd0;
      r_shift  <= 32'd0;
      r_addr   <= '0;
      r_cfg    <= 8'h00;
      r_err    <= 1'b0;
      r_io_out <= 8'h00;
      r_io_en  <= 8'h00;
`ifdef PSRAM_RESP_DQS_EN
      r_dqs_out <= 1'b0;
      r_dqs_en  <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_op     <= w_op_next;
      r_mode   <= w_mode_next;
      r_cnt    <= w_cnt_next;
      r_shift  <= w_shift_next;
      r_addr   <= w_addr_next;
      r_cfg    <= w_cfg_next;
      r_err    <= w_err_next;
      r_io_out <= w_io_out_next;
      r_io_en  <= w_io_en_next;
`ifdef PSRAM_RESP_DQS_EN
      r_dqs_out <= w_dqs_out_next;
      r_dqs_en  <= w_dqs_en_next;
`endif
    end
  end

  // Backing store with registered read. The read port follows r_addr every
  // cycle; an SCK half-period of 4+ clocks leaves it settled before use.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= w_shift_in[7:0];
    end
    r_mem_q <= r_mem[r_addr];
  end

  assign psram_io_out_o = r_io_out;
  assign psram_io_en_o  = r_io_en;
  assign cfg_o          = r_cfg;
  assign err_o          = r_err;
  assign busy_o         = (r_state != PSRAM_RESP_FSM_IDLE);

`ifdef PSRAM_RESP_DQS_EN
  assign psram_dqs_out_o = r_dqs_out;
  assign psram_dqs_en_o  = r_dqs_en;
`else
  assign psram_dqs_out_o = 1'b0;
  assign psram_dqs_en_o  = 1'b0;
`endif

endmodule

// File: tb/tb_psram_resp.sv
// Testbench for psram_resp: acts as the PSRAM controller, driving SCK at
// clk/8 and checking read-back data against a byte-array reference model.
module tb_psram_resp;
  import psram_resp_pkg::*;

  localparam int DEPTH = 1024;
  localparam logic [7:0] WCMD = 8'h38;
  localparam logic [7:0] RCMD = 8'hEB;
  localparam logic [7:0] CCMD = 8'hC0;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic [1:0] mode_i = PSRAM_MODE_SPI;
  logic [7:0] wcmd_i = WCMD;
  logic [7:0] rcmd_i = RCMD;
  logic [7:0] ccmd_i = CCMD;
  logic [7:0] wlc_i = 8'd0;
  logic [7:0] rlc_i = 8'd0;
  logic       psram_sck_i = 1'b0;
  logic       psram_ce_i = 1'b1;
  logic [7:0] psram_io_in_i = 8'h00;
  logic [7:0] psram_io_out_o;
  logic [7:0] psram_io_en_o;
  logic       psram_dqs_out_o;
  logic       psram_dqs_en_o;
  logic [7:0] cfg_o;
  logic       busy_o;
  logic       err_o;

  psram_resp #(.DEPTH(DEPTH), .SYNC_STAGE(2)) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .mode_i          (mode_i),
    .wcmd_i          (wcmd_i),
    .rcmd_i          (rcmd_i),
    .ccmd_i          (ccmd_i),
    .wlc_i           (wlc_i),
    .rlc_i           (rlc_i),
    .psram_sck_i     (psram_sck_i),
    .psram_ce_i      (psram_ce_i),
    .psram_io_in_i   (psram_io_in_i),
    .psram_io_out_o  (psram_io_out_o),
    .psram_io_en_o   (psram_io_en_o),
    .psram_dqs_out_o (psram_dqs_out_o),
    .psram_dqs_en_o  (psram_dqs_en_o),
    .cfg_o           (cfg_o),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int en_cnt = 0;

  always @(posedge clk_i) begin
    if (err_o) err_cnt <= err_cnt + 1;
    if (|psram_io_en_o) en_cnt <= en_cnt + 1;
  end

  logic [7:0] model_mem [DEPTH];
  logic [7:0] tx_buf [8];
  logic [7:0] rx_buf [8];
  logic [7:0] rx_en;

  typedef struct {
    logic [1:0]  wmode;
    logic [31:0] waddr;
    int          wn;
    logic [31:0] wdata;
    logic [7:0]  wlc;
    logic [1:0]  rmode;
    logic [31:0] raddr;
    int          rn;
    logic [7:0]  rlc;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  function automatic int inst_lanes(input logic [1:0] m);
    if (m == PSRAM_MODE_QPI) return 4;
    if (m == PSRAM_MODE_OPI) return 8;
    return 1;
  endfunction

  function automatic int data_lanes(input logic [1:0] m);
    if (m == PSRAM_MODE_SPI) return 1;
    if (m == PSRAM_MODE_OPI) return 8;
    return 4;
  endfunction

  function automatic logic [7:0] lane_mask(input logic [1:0] m);
    if (m == PSRAM_MODE_SPI) return 8'h02;
    if (m == PSRAM_MODE_OPI) return 8'hFF;
    return 8'h0F;
  endfunction

  // One SCK period: IO set while SCK low, outputs sampled just before rise.
  task automatic pulse(input logic [7:0] io, output logic [7:0] smp, output logic [7:0] en);
    psram_io_in_i = io;
    repeat (4) @(negedge clk_i);
    smp = psram_io_out_o;
    en  = psram_io_en_o;
    psram_sck_i = 1'b1;
    repeat (4) @(negedge clk_i);
    psram_sck_i = 1'b0;
  endtask

  task automatic send(input logic [31:0] val, input int nbits, input int lanes);
    logic [7:0] s, e, c;
    for (int i = 0; i < nbits / lanes; i++) begin
      c = 8'((val >> (nbits - lanes * (i + 1))) & ((32'd1 << lanes) - 32'd1));
      pulse(c, s, e);
    end
  endtask

  task automatic dummy(input int n);
    logic [7:0] s, e;
    for (int i = 0; i < n; i++) pulse(8'h00, s, e);
  endtask

  task automatic recv_byte(input logic [1:0] m, output logic [7:0] b, output logic [7:0] en);
    logic [7:0] s, e, c;
    int l;
    l = data_lanes(m);
    b = 8'h00;
    en = 8'h00;
    for (int i = 0; i < 8 / l; i++) begin
      pulse(8'h00, s, e);
      if (i == 0) en = e;
      c = (l == 1) ? {7'b0, s[1]} : (l == 4) ? {4'h0, s[3:0]} : s;
      b = 8'((b << l) | c);
    end
  endtask

  task automatic start_txn(input logic [1:0] m, input logic [7:0] inst, input logic [31:0] addr);
    mode_i = m;
    psram_ce_i = 1'b0;
    repeat (4) @(negedge clk_i);
    send({24'h0, inst}, 8, inst_lanes(m));
    send(addr, 32, data_lanes(m));
  endtask

  task automatic end_txn;
    repeat (4) @(negedge clk_i);
    psram_ce_i = 1'b1;
    repeat (8) @(negedge clk_i);
  endtask

  task automatic do_write(input logic [1:0] m, input logic [31:0] addr, input int n);
    logic [31:0] t;
    start_txn(m, WCMD, addr);
    dummy(int'(wlc_i));
    for (int i = 0; i < n; i++) begin
      send({24'h0, tx_buf[i]}, 8, data_lanes(m));
      t = addr + 32'(i);
      model_mem[t % DEPTH] = tx_buf[i];
    end
    end_txn();
  endtask

  task automatic do_read(input logic [1:0] m, input logic [31:0] addr, input int n);
    logic [7:0] b, e;
    start_txn(m, RCMD, addr);
    dummy(int'(rlc_i));
    for (int i = 0; i < n; i++) begin
      recv_byte(m, b, e);
      rx_buf[i] = b;
      if (i == 0) rx_en = e;
    end
    end_txn();
  endtask

  initial begin
    logic [1:0]  m, rm;
    logic [31:0] a, t;
    int          n, off, e0, en0;

    vecs[0] = '{PSRAM_MODE_SPI,  32'h010, 2, 32'hA55A0000, 8'd0, PSRAM_MODE_SPI,  32'h010, 2, 8'd6, 32'hA55A0000};
    vecs[1] = '{PSRAM_MODE_OPI,  32'h3FE, 4, 32'h11223344, 8'd1, PSRAM_MODE_OPI,  32'h000, 2, 8'd2, 32'h33440000};
    vecs[2] = '{PSRAM_MODE_QSPI, 32'h100, 4, 32'hDEADBEEF, 8'd3, PSRAM_MODE_QPI,  32'h101, 3, 8'd1, 32'hADBEEF00};
    vecs[3] = '{PSRAM_MODE_QPI,  32'h200, 4, 32'h0180FF00, 8'd0, PSRAM_MODE_SPI,  32'h200, 4, 8'd0, 32'h0180FF00};
    vecs[4] = '{PSRAM_MODE_SPI,  32'h3FF, 2, 32'hC33C0000, 8'd2, PSRAM_MODE_QSPI, 32'h3FF, 2, 8'd4, 32'hC33C0000};
    vecs[5] = '{PSRAM_MODE_SPI,  32'h000, 0, 32'h00000000, 8'd0, PSRAM_MODE_OPI,  32'h3FE, 4, 8'd0, 32'h11C33C44};

    // Reset state
    repeat (5) @(negedge clk_i);
    check("rst_io_out", {24'h0, psram_io_out_o}, 32'h0);
    check("rst_io_en", {24'h0, psram_io_en_o}, 32'h0);
    check("rst_dqs", {30'h0, psram_dqs_out_o, psram_dqs_en_o}, 32'h0);
    check("rst_cfg", {24'h0, cfg_o}, 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    check("rst_err", {31'h0, err_o}, 32'h0);
    rst_n_i = 1'b1;
    repeat (5) @(negedge clk_i);

    // Directed table: write, then read back with expected bytes
    for (int v = 0; v < 6; v++) begin
      wlc_i = vecs[v].wlc;
      rlc_i = vecs[v].rlc;
      for (int i = 0; i < 4; i++) tx_buf[i] = vecs[v].wdata[31 - 8 * i -: 8];
      if (vecs[v].wn > 0) do_write(vecs[v].wmode, vecs[v].waddr, vecs[v].wn);
      do_read(vecs[v].rmode, vecs[v].raddr, vecs[v].rn);
      for (int i = 0; i < vecs[v].rn; i++)
        check($sformatf("vec%0d_byte%0d", v, i), {24'h0, rx_buf[i]}, {24'h0, vecs[v].exp_data[31 - 8 * i -: 8]});
      check($sformatf("vec%0d_io_en", v), {24'h0, rx_en}, {24'h0, lane_mask(vecs[v].rmode)});
      $display("vec %0d: wmode %0d waddr 0x%0h rmode %0d raddr 0x%0h n %0d", v, vecs[v].wmode,
               vecs[v].waddr, vecs[v].rmode, vecs[v].raddr, vecs[v].rn);
    end

    // Randomized write/read-back against the model
    for (int it = 0; it < 14; it++) begin
      m  = 2'($urandom_range(0, 3));
      rm = 2'($urandom_range(0, 3));
      a  = $urandom();
      n  = $urandom_range(1, 4);
      off = $urandom_range(0, n - 1);
      wlc_i = 8'($urandom_range(0, 3));
      rlc_i = 8'($urandom_range(0, 3));
      for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom());
      do_write(m, a, n);
      do_read(rm, a + 32'(off), n - off);
      for (int i = 0; i < n - off; i++) begin
        t = a + 32'(off + i);
        check($sformatf("rand%0d_byte%0d", it, i), {24'h0, rx_buf[i]}, {24'h0, model_mem[t % DEPTH]});
      end
      $display("rand %0d: wmode %0d rmode %0d addr 0x%0h n %0d off %0d", it, m, rm, a, n, off);
    end

    // Unknown instruction in QPI
    e0  = err_cnt;
    en0 = en_cnt;
    mode_i = PSRAM_MODE_QPI;
    psram_ce_i = 1'b0;
    repeat (4) @(negedge clk_i);
    send(32'h77, 8, 4);
    send(32'hFFFF, 16, 4);
    check("ignr_busy", {31'h0, busy_o}, 32'h1);
    end_txn();
    check("ignr_busy_drop", {31'h0, busy_o}, 32'h0);
    check("ignr_err_pulses", 32'(err_cnt - e0), 32'h1);
    check("ignr_io_en_cycles", 32'(en_cnt - en0), 32'h0);
    $display("unknown inst 0x77 QPI: err pulses %0d", err_cnt - e0);

    // CE abort after 3 SPI data bits leaves memory untouched
    wlc_i = 8'd0;
    rlc_i = 8'd2;
    tx_buf[0] = 8'h11;
    do_write(PSRAM_MODE_SPI, 32'h40, 1);
    start_txn(PSRAM_MODE_SPI, WCMD, 32'h40);
    send(32'h7, 3, 1);
    end_txn();
    check("abort_busy", {31'h0, busy_o}, 32'h0);
    do_read(PSRAM_MODE_SPI, 32'h40, 1);
    check("abort_mem", {24'h0, rx_buf[0]}, {24'h0, model_mem[32'h40]});
    $display("ce abort: addr 0x40 reads 0x%0h", rx_buf[0]);

    // Config write ignores write latency
    wlc_i = 8'd5;
    start_txn(PSRAM_MODE_QPI, CCMD, 32'h0);
    send(32'h2B, 8, 4);
    end_txn();
    check("cfg_value", {24'h0, cfg_o}, 32'h2B);
    $display("cfg write: cfg_o 0x%0h", cfg_o);

    // Reset in the middle of a read
    wlc_i = 8'd0;
    rlc_i = 8'd1;
    tx_buf[0] = 8'h5C;
    tx_buf[1] = 8'hC5;
    do_write(PSRAM_MODE_OPI, 32'h80, 2);
    start_txn(PSRAM_MODE_SPI, RCMD, 32'h80);
    dummy(1);
    recv_byte(PSRAM_MODE_SPI, rx_buf[0], rx_en);
    check("midrst_first_byte", {24'h0, rx_buf[0]}, 32'h5C);
    dummy(3);
    rst_n_i = 1'b0;
    #1;
    check("midrst_io_en", {24'h0, psram_io_en_o}, 32'h0);
    check("midrst_io_out", {24'h0, psram_io_out_o}, 32'h0);
    check("midrst_busy", {31'h0, busy_o}, 32'h0);
    check("midrst_cfg", {24'h0, cfg_o}, 32'h0);
    psram_ce_i = 1'b1;
    psram_sck_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (4) @(negedge clk_i);
    do_read(PSRAM_MODE_SPI, 32'h80, 2);
    check("midrst_reread0", {24'h0, rx_buf[0]}, 32'h5C);
    check("midrst_reread1", {24'h0, rx_buf[1]}, 32'hC5);
    $display("mid-read reset: re-read 0x%0h 0x%0h", rx_buf[0], rx_buf[1]);

    check("total_err_pulses", 32'(err_cnt), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
